csr_pins_in: RTL and testbench
==============================

# csr_pins_in

CSR-mapped input-pin block for push buttons and slide switches: the read-side counterpart of the LED output CSR. Each pin is synchronised, debounced and edge-detected. Software reads debounced levels and sticky rising-edge flags through the pipeline's CSR port, and an interrupt line is available to feed `irq_external`. The block sits beside the UART and LED responders in board wrappers; its `rdata`/`valid` are OR-ed into the pipeline's `csr_rdata`/`csr_valid`.

## Interface
- `BASE_ADDR`, 12'hBC2: CSR address of PINS. PENDING is at +1 and ENABLE at +2.
- `COUNT`, 5: number of pins, legal range 1..32.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive cycles a changed level must persist (5 ms at 200 MHz); minimum 1.
- `clk`  in  1: single clock. Everything is on the rising edge.
- `rst`  in  1: synchronous, active-high reset. The wrapper drives it with `!rstn`.
- `read`  in  1: CSR access strobe from the pipeline.
- `modify`  in  3: one-hot operation. [0] = write, [1] = set, [2] = clear. 000 means no modification.
- `wdata`  in  32: CSR write operand.
- `addr`  in  12: CSR address.
- `rdata`  out  32: read data; 0 whenever `valid` is 0.
- `valid`  out  1: asserted when the address hits one of the three CSRs.
- `pins`  in  COUNT: asynchronous raw pin inputs.
- `irq`  out  1: OR of (PENDING & ENABLE).
- `AVOID_WARNING`  —  —: unconnected dummy port.

## Operation
- **Synchroniser:** two-flop chain per pin, `pins` → `s1` → `s2`.
- **Debounce (per pin):**
  - `stable` is the debounced level and `cnt` is the counter.
  - If `s2 == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0` (commit).
  - Else: `cnt <= cnt+1`.
  - `cnt` width is `$clog2(DEBOUNCE_CYCLES)`, minimum 1 bit; it never wraps.
- **Edge detection:** a commit with `s2 = 1` is a rising edge and sets `PENDING[i]`. Falling commits only update `stable`.
- **PINS (BASE+0):** read-only. Bits [COUNT-1:0] = `stable`, upper bits 0. All modify operations are ignored.
- **PENDING (BASE+1):** sticky, write-1-to-clear.
  - Write or clear: bits where `wdata = 1` are cleared.
  - Set: ignored.
  - A hardware set in the same cycle as a software clear of the same bit leaves the bit at 1 (hardware wins).
- **ENABLE (BASE+2):**
  - Write: `ENABLE <= wdata`.
  - Set: `ENABLE |= wdata`.
  - Clear: `ENABLE &= ~wdata`.
  - Bits at and above COUNT always read 0.
- **Access conditions:** modify takes effect only when `addr` hits and `modify != 0`; `read` is not required for a modify. Non-matching addresses cause no state change.
- **Reset:** `s1`, `s2`, `stable`, `cnt`, PENDING and ENABLE all clear to 0. Reset mid-debounce discards the count. A pin held high through reset commits DEBOUNCE_CYCLES+2 edges after reset deasserts and sets PENDING.
- **Reset values of outputs:** `rdata` = 0, `valid` = 0, `irq` = 0.

## Timing
- `valid`/`rdata` are combinational from `read`/`addr` and the registered state; they are valid in the same cycle as the access.
  - `valid = read & (addr in BASE..BASE+2)`.
- Read-before-modify: `rdata` returns the pre-modify value; the new value is visible from the next cycle.
- Pin-to-PINS latency: after a pin change, `stable`/PENDING update on the (DEBOUNCE_CYCLES+2)th rising edge. A run shorter than DEBOUNCE_CYCLES cycles at the `s2` stage never commits.
- `irq` is combinational from flops and glitch-free. It rises the cycle after a commit to an enabled bit and falls the cycle after the clear.

## Structure
- Shared package `csr_pkg` holds:
  - `CSR_MOD_WRITE` = 3'b001, `CSR_MOD_SET` = 3'b010, `CSR_MOD_CLEAR` = 3'b100.
  - Register offsets `PINS_OFS` = 0, `PENDING_OFS` = 1, `ENABLE_OFS` = 2.
- Sub-module `pin_debounce`: one instance per pin (generate loop). It contains the synchroniser, counter and `stable`, and outputs `level` plus a one-cycle `rise` pulse.
- The top level holds the CSR decode, PENDING, ENABLE and `irq`.

## Test plan
All scenarios use `COUNT=5`, `DEBOUNCE_CYCLES=4`, `BASE_ADDR=12'hBC2`.
- **Reset:** assert `rst` 2 cycles with pins = 0, read BC2/BC3/BC4 → `valid`=1, `rdata`=0 each; `irq`=0; read BC5 → `valid`=0, `rdata`=0.
- **Clean press:** raise `pins[0]` and hold → PINS reads 0x01 and PENDING 0x01 starting exactly 6 edges after the change. Lower the pin → PINS returns to 0x00 after 6 edges; PENDING stays 0x01.
- **Glitch rejection:** `pins[2]` high for 3 cycles then low → PINS and PENDING remain 0 throughout.
- **Interrupt:**
  - ENABLE write 0x01, then press pin 0 → `irq`=1 the cycle after the commit.
  - PENDING write 0x02 → bit 0 unchanged, `irq` stays 1.
  - PENDING write 0x01 → `irq`=0 next cycle.
  - ENABLE set 0x10 then clear 0x01 → ENABLE reads 0x10.
- **Collision:** PENDING clear 0x08 issued in the same cycle as the pin-3 rising commit → PENDING reads 0x08.
- **Reset mid-debounce:**
  - Raise `pins[1]`, assert `rst` on the 4th cycle for 1 cycle → PINS reads 0 immediately after.
  - Keep `pins[1]` held → PINS = 0x02 and PENDING = 0x02 on the 6th edge after reset deasserts.
  - Writes to PINS (0xFF) → PINS unchanged.

Source files
------------

// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : csr_pkg
//  Purpose  : Shared CSR definitions: one-hot modify encodings and the
//             register offsets of the input-pin CSR block.
//  Revision : 1.0  initial release
// ============================================================================
package csr_pkg;

    // One-hot CSR modify operations as delivered by the pipeline.
    localparam logic [2:0] CSR_MOD_WRITE = 3'b001;
    localparam logic [2:0] CSR_MOD_SET   = 3'b010;
    localparam logic [2:0] CSR_MOD_CLEAR = 3'b100;

    // Register offsets relative to the block base address.
    localparam logic [11:0] PINS_OFS    = 12'd0;
    localparam logic [11:0] PENDING_OFS = 12'd1;
    localparam logic [11:0] ENABLE_OFS  = 12'd2;

endpackage : csr_pkg
`default_nettype wire

// File: rtl/pin_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : pin_debounce
//  Purpose  : Per-pin two-flop synchroniser followed by a persistence
//             debouncer. A level change at the synchroniser output must hold
//             for DEBOUNCE_CYCLES consecutive cycles before it is committed.
//  Ports    : clk, rst   - clock, synchronous active-high reset
//             pin        - asynchronous raw pin input
//             level      - debounced (committed) level
//             rise       - high in the cycle whose edge commits a 0->1 change
//  Revision : 1.0  initial release
// ============================================================================
module pin_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_s1;
    logic               r_s2;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_commit;

    // Commit happens on the edge where the differing level has already been
    // seen DEBOUNCE_CYCLES-1 times; the counter therefore never wraps.
    assign w_commit = (r_s2 != r_stable) && (r_cnt == c_cnt_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= pin;
            r_s2 <= r_s1;
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_commit) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_stable;
    // Combinational so that PENDING is set on the same edge that updates level.
    assign rise  = w_commit & r_s2;

endmodule : pin_debounce
`default_nettype wire

// File: rtl/csr_pins_in.sv
`default_nettype none
// ============================================================================
//  Module   : csr_pins_in
//  Purpose  : CSR-mapped input pins (buttons/switches). Debounced levels are
//             readable at PINS, rising edges latch into sticky PENDING
//             (write-1-to-clear), and irq = |(PENDING & ENABLE).
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             read, addr      - CSR access strobe and address
//             modify, wdata   - one-hot modify op (write/set/clear), operand
//             rdata, valid    - read data (0 unless valid), address hit
//             pins            - raw asynchronous pin inputs
//             irq             - interrupt request
//             AVOID_WARNING   - unused dummy input
//  Revision : 1.0  initial release
// ============================================================================
module csr_pins_in
    import csr_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR       = 12'hBC2,
    parameter int          COUNT           = 5,
    parameter int          DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic [2:0]        modify,
    input  logic [31:0]       wdata,
    input  logic [11:0]       addr,
    output logic [31:0]       rdata,
    output logic              valid,
    input  logic [COUNT-1:0]  pins,
    output logic              irq,
    input  logic              AVOID_WARNING
);

    logic [COUNT-1:0] w_level;
    logic [COUNT-1:0] w_rise;
    logic [COUNT-1:0] r_pending;
    logic [COUNT-1:0] r_enable;
    logic [COUNT-1:0] w_enable_nxt;
    logic [COUNT-1:0] w_pend_clr;
    logic             w_hit_pins;
    logic             w_hit_pend;
    logic             w_hit_en;
    logic             w_unused;

    generate
        for (genvar i = 0; i < COUNT; i++) begin : g_pin
            pin_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_pin_debounce (
                .clk   (clk),
                .rst   (rst),
                .pin   (pins[i]),
                .level (w_level[i]),
                .rise  (w_rise[i])
            );
        end
    endgenerate

    assign w_hit_pins = (addr == BASE_ADDR + PINS_OFS);
    assign w_hit_pend = (addr == BASE_ADDR + PENDING_OFS);
    assign w_hit_en   = (addr == BASE_ADDR + ENABLE_OFS);

    // PENDING: write and clear both act as write-1-to-clear; set is ignored.
    assign w_pend_clr = (w_hit_pend && (modify == CSR_MOD_WRITE || modify == CSR_MOD_CLEAR))
                      ? wdata[COUNT-1:0] : '0;

    always_comb begin
        w_enable_nxt = r_enable;
        if (w_hit_en) begin
            case (modify)
                CSR_MOD_WRITE: w_enable_nxt = wdata[COUNT-1:0];
                CSR_MOD_SET:   w_enable_nxt = r_enable | wdata[COUNT-1:0];
                CSR_MOD_CLEAR: w_enable_nxt = r_enable & ~wdata[COUNT-1:0];
                default:       w_enable_nxt = r_enable;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_enable  <= '0;
        end else begin
            // Rise is OR-ed in after the clear so a same-cycle hardware set wins.
            r_pending <= (r_pending & ~w_pend_clr) | w_rise;
            r_enable  <= w_enable_nxt;
        end
    end

    assign valid = read & (w_hit_pins | w_hit_pend | w_hit_en);

    always_comb begin
        rdata = '0;
        if (valid) begin
            if (w_hit_pins)      rdata = 32'(w_level);
            else if (w_hit_pend) rdata = 32'(r_pending);
            else                 rdata = 32'(r_enable);
        end
    end

    assign irq = |(r_pending & r_enable);

    assign w_unused = ^{AVOID_WARNING, wdata};

endmodule : csr_pins_in
`default_nettype wire

// File: tb/tb_csr_pins_in.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_pins_in
//  Purpose  : Self-checking bench for csr_pins_in (COUNT=5, DEBOUNCE_CYCLES=4).
//             Directed stimulus pushes expected read responses into a queue;
//             a negedge monitor pops and compares on every read cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csr_pins_in;

    localparam logic [11:0] c_base = 12'hBC2;
    localparam logic [11:0] c_pins = 12'hBC2;
    localparam logic [11:0] c_pend = 12'hBC3;
    localparam logic [11:0] c_en   = 12'hBC4;
    localparam logic [2:0]  c_wr   = 3'b001;
    localparam logic [2:0]  c_set  = 3'b010;
    localparam logic [2:0]  c_clr  = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic        read;
    logic [2:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic [4:0]  pins;
    logic        irq;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        irq;
    } exp_t;

    exp_t  q_exp[$];
    string q_name[$];
    int    n_cmp = 0;
    int    n_err = 0;

    csr_pins_in #(
        .BASE_ADDR       (c_base),
        .COUNT           (5),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .read          (read),
        .modify        (modify),
        .wdata         (wdata),
        .addr          (addr),
        .rdata         (rdata),
        .valid         (valid),
        .pins          (pins),
        .irq           (irq),
        .AVOID_WARNING (1'b0)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle with read asserted presents a response to check.
    always @(negedge clk) begin
        if (read) begin
            if (q_exp.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_read: no expected entry queued, got valid=%0b rdata=0x%08h",
                         valid, rdata);
            end else begin
                exp_t  e;
                string nm;
                e  = q_exp.pop_front();
                nm = q_name.pop_front();
                n_cmp++;
                if (valid !== e.v || rdata !== e.d || irq !== e.irq) begin
                    n_err++;
                    $display("FAIL %s: got valid=%0b rdata=0x%08h irq=%0b, required valid=%0b rdata=0x%08h irq=%0b",
                             nm, valid, rdata, irq, e.v, e.d, e.irq);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read (optionally combined with a modify) and queue the expected response.
    task automatic access(input logic [11:0] a, input logic [2:0] m, input logic [31:0] wd,
                          input logic ev, input logic [31:0] ed, input logic ei, input string nm);
        exp_t e;
        e.v = ev; e.d = ed; e.irq = ei;
        q_exp.push_back(e);
        q_name.push_back(nm);
        read = 1'b1; addr = a; modify = m; wdata = wd;
        tick();
        read = 1'b0; modify = 3'b000; wdata = '0;
    endtask

    task automatic rd(input logic [11:0] a, input logic ev, input logic [31:0] ed,
                      input logic ei, input string nm);
        access(a, 3'b000, 32'h0, ev, ed, ei, nm);
    endtask

    task automatic mod(input logic [11:0] a, input logic [2:0] m, input logic [31:0] wd);
        read = 1'b0; addr = a; modify = m; wdata = wd;
        tick();
        modify = 3'b000; wdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; read = 1'b0; modify = 3'b000; wdata = '0; addr = '0; pins = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        rd(c_pins, 1, 0, 0, "reset_pins");
        rd(c_pend, 1, 0, 0, "reset_pending");
        rd(c_en,   1, 0, 0, "reset_enable");
        rd(12'hBC5, 0, 0, 0, "reset_miss");

        // Clean press / release of pin 0: commit exactly on the 6th edge
        pins = 5'b00001;
        repeat (5) tick();
        rd(c_pins, 1, 32'h00, 0, "press_before_commit");
        rd(c_pins, 1, 32'h01, 0, "press_pins");
        rd(c_pend, 1, 32'h01, 0, "press_pending");
        pins = 5'b00000;
        repeat (5) tick();
        rd(c_pins, 1, 32'h01, 0, "release_before_commit");
        rd(c_pins, 1, 32'h00, 0, "release_pins");
        rd(c_pend, 1, 32'h01, 0, "release_pending_sticky");
        mod(c_pend, c_wr, 32'h01);
        rd(c_pend, 1, 32'h00, 0, "pending_cleared");

        // Glitch rejection: 3-cycle pulse on pin 2
        pins = 5'b00100;
        repeat (3) tick();
        pins = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            rd(c_pins, 1, 32'h00, 0, "glitch_pins");
            rd(c_pend, 1, 32'h00, 0, "glitch_pending");
        end

        // Interrupt path
        mod(c_en, c_wr, 32'h01);
        rd(c_en, 1, 32'h01, 0, "enable_write");
        pins = 5'b00001;
        repeat (5) tick();
        rd(c_pend, 1, 32'h00, 0, "irq_before_commit");
        rd(c_pend, 1, 32'h01, 1, "irq_after_commit");
        mod(c_pend, c_wr, 32'h02);
        rd(c_pend, 1, 32'h01, 1, "w1c_other_bit");
        mod(c_pend, c_wr, 32'h01);
        rd(c_pend, 1, 32'h00, 0, "w1c_irq_drop");
        access(c_en, c_set, 32'h10, 1, 32'h01, 0, "enable_set_rbm");
        access(c_en, c_clr, 32'h01, 1, 32'h11, 0, "enable_clear_rbm");
        rd(c_en, 1, 32'h10, 0, "enable_after_clear");
        mod(c_en, c_set, 32'hFFFF_FF00);
        rd(c_en, 1, 32'h10, 0, "enable_upper_bits");
        mod(c_pend, c_set, 32'h1F);
        rd(c_pend, 1, 32'h00, 0, "pending_set_ignored");
        pins = 5'b00000;
        repeat (8) tick();
        rd(c_pins, 1, 32'h00, 0, "pin0_released");

        // Collision: software clear on the same edge as the pin-3 commit
        pins = 5'b01000;
        repeat (5) tick();
        mod(c_pend, c_clr, 32'h08);
        rd(c_pend, 1, 32'h08, 0, "collision_hw_wins");
        rd(c_pins, 1, 32'h08, 0, "collision_pins");
        mod(c_pend, c_clr, 32'h08);
        rd(c_pend, 1, 32'h00, 0, "pending_clear_op");
        pins = 5'b00000;
        repeat (8) tick();

        // Reset mid-debounce on pin 1
        pins = 5'b00010;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(c_pins, 1, 32'h00, 0, "midreset_pins");
        repeat (4) tick();
        rd(c_pins, 1, 32'h00, 0, "midreset_before_commit");
        rd(c_pins, 1, 32'h02, 0, "midreset_commit_pins");
        rd(c_pend, 1, 32'h02, 0, "midreset_commit_pending");
        rd(c_en,   1, 32'h00, 0, "midreset_enable");
        access(c_pins, c_wr, 32'hFF, 1, 32'h02, 0, "pins_write_rbm");
        rd(c_pins, 1, 32'h02, 0, "pins_readonly");
        rd(12'hBC1, 0, 32'h00, 0, "below_base_miss");

        tick();
        if (q_exp.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL queue_drain: %0d entries left, required 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_csr_pins_in
`default_nettype wire
